// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Instruction layout, field slices and fetch FSM states.
package instr_fetch_pkg;

  localparam int INSTR_W = 9;
  localparam int MSB_BIT = 8;
  localparam int OPC_HI  = 7;
  localparam int OPC_LO  = 5;
  localparam int OPD_HI  = 4;
  localparam int OPD_LO  = 0;

  typedef enum logic [1:0] {
    F_IDLE,
    F_FETCH,
    F_ISSUE,
    F_HALTED
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Combinational next-PC selection: hold, +1 or +sext(offset).
// All arithmetic wraps modulo 2**PC_W.
module instr_fetch_pc_next #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8
) (
  input  logic [PC_W-1:0]  pc_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic             taken_i,
  input  logic             hold_i,
  output logic [PC_W-1:0]  pc_o
);

  logic [PC_W-1:0] off_ext;

  assign off_ext = {{(PC_W-OFF_W){off_i[OFF_W-1]}}, off_i};

  always_comb begin
    pc_o = pc_i + PC_W'(1);
    if (hold_i) begin
      pc_o = pc_i;
    end else if (taken_i) begin
      pc_o = pc_i + off_ext;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads imem via req/ack, holds the
// decoded instruction until execute retires it.
import instr_fetch_pkg::*;

module instr_fetch #(
  parameter int              PC_W     = 10,
  parameter int              OFF_W    = 8,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic               msb,
  output logic [2:0]         opCode,
  output logic [4:0]         operand,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               branch_taken,
  input  logic [OFF_W-1:0]   branch_offset,
  input  logic               halt,
  output logic [PC_W-1:0]    pc,
  output logic               done
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_nxt;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  instr_fetch_pc_next #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_pc_next (
    .pc_i    (pc_q),
    .off_i   (branch_offset),
    .taken_i (branch_taken),
    .hold_i  (halt),
    .pc_o    (pc_nxt)
  );

  // Flags are computed for the next state so outputs come straight off flops.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      F_IDLE: begin
        if (start) begin
          state_d = F_FETCH;
          req_d   = 1'b1;
        end
      end
      F_FETCH: begin
        req_d = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = F_ISSUE;
        end
      end
      F_ISSUE: begin
        valid_d = 1'b1;
        if (exec_done) begin
          valid_d = 1'b0;
          pc_d    = pc_nxt;
          if (halt) begin
            state_d = F_HALTED;
            done_d  = 1'b1;
          end else begin
            state_d = F_FETCH;
            req_d   = 1'b1;
          end
        end
      end
      F_HALTED: begin
        done_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= F_IDLE;
      pc_q    <= START_PC;
      ir_q    <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = valid_q;
  assign done        = done_q;
  assign msb         = ir_q[MSB_BIT];
  assign opCode      = ir_q[OPC_HI:OPC_LO];
  assign operand     = ir_q[OPD_HI:OPD_LO];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a transaction-level
// reference model and a per-cycle compare process.
module tb_instr_fetch;

  logic       clk;
  logic       reset;
  logic       start;
  logic       imem_req;
  logic [9:0] imem_addr;
  logic [8:0] imem_rdata;
  logic       imem_ack;
  logic       msb;
  logic [2:0] opCode;
  logic [4:0] operand;
  logic       instr_valid;
  logic       exec_done;
  logic       branch_taken;
  logic [7:0] branch_offset;
  logic       halt;
  logic [9:0] pc;
  logic       done;

  instr_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ack      (imem_ack),
    .msb           (msb),
    .opCode        (opCode),
    .operand       (operand),
    .instr_valid   (instr_valid),
    .exec_done     (exec_done),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .halt          (halt),
    .pc            (pc),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] mem [1024];
  int npass = 0;
  int ntot  = 0;
  bit chk_en = 0;

  int m_pc;
  logic [8:0] m_ir;
  bit m_req, m_valid, m_halt, m_idle;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: what the stage must show, from its event-level rules.
  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0; m_ir = '0; m_req = 0; m_valid = 0; m_halt = 0; m_idle = 1;
    end else if (m_idle) begin
      if (start) begin m_idle = 0; m_req = 1; end
    end else if (m_req) begin
      if (imem_ack) begin m_req = 0; m_valid = 1; m_ir = mem[m_pc]; end
    end else if (m_valid) begin
      if (exec_done) begin
        m_valid = 0;
        if (halt) m_halt = 1;
        else begin
          if (branch_taken)
            m_pc = ((m_pc + int'($signed(branch_offset))) % 1024 + 1024) % 1024;
          else
            m_pc = (m_pc + 1) % 1024;
          m_req = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("imem_req", imem_req, m_req);
      check("instr_valid", instr_valid, m_valid);
      check("done", done, m_halt);
      if (m_req) check("imem_addr", imem_addr, m_pc);
      if (m_valid) check("fields", {msb, opCode, operand}, m_ir);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Memory side: ack after lat wait cycles; exec_done noise must be ignored.
  task automatic fetch(input int lat, output int addr);
    int n = 0;
    addr = -1;
    while (!imem_req && n < 20) begin step(); n++; end
    if (!imem_req) begin
      check("fetch_timeout", imem_req, 1);
      return;
    end
    repeat (lat) begin
      exec_done = 1'b1; halt = 1'b1; branch_taken = 1'b1;
      step();
    end
    exec_done = 1'b0; halt = 1'b0; branch_taken = 1'b0;
    addr = int'(imem_addr);
    imem_ack = 1'b1;
    imem_rdata = mem[imem_addr];
    step();
    imem_ack = 1'b0;
  endtask

  // Execute side: retire after lat cycles; stray imem_ack must be ignored.
  task automatic exec(input int lat, input logic tk, input logic [7:0] off,
                      input logic hl);
    int n = 0;
    while (!instr_valid && n < 20) begin step(); n++; end
    if (!instr_valid) begin
      check("exec_timeout", instr_valid, 1);
      return;
    end
    repeat (lat) begin
      imem_ack = 1'b1; imem_rdata = 9'h1FF;
      step();
    end
    imem_ack = 1'b0;
    exec_done = 1'b1; branch_taken = tk; branch_offset = off; halt = hl;
    step();
    exec_done = 1'b0; branch_taken = 1'b0; branch_offset = 8'h00; halt = 1'b0;
  endtask

  initial begin
    int a;
    reset = 1'b1; start = 1'b0; imem_rdata = '0; imem_ack = 1'b0;
    exec_done = 1'b0; branch_taken = 1'b0; branch_offset = '0; halt = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 9'((i * 37 + 11) % 512);
    step();
    chk_en = 1;
    step();
    check("rst_pc", pc, 0);
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_done", done, 0);
    check("rst_fields", {msb, opCode, operand}, 0);

    // basic fetch, ack after two wait cycles
    mem[0] = 9'h1A5;
    reset = 1'b0;
    step();
    do_start();
    fetch(2, a);
    check("t1_addr", a, 0);
    check("t1_msb", msb, 1);
    check("t1_opc", opCode, 3'b101);
    check("t1_opd", operand, 5'b00101);
    check("t1_valid", instr_valid, 1);
    check("t1_pc", pc, 0);
    exec(1, 1'b0, 8'h00, 1'b0);
    check("t1_pc_adv", pc, 1);

    // reset during FETCH with a simultaneous ack
    step();
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 9'h0FF;
    step();
    reset = 1'b0; imem_ack = 1'b0;
    check("t6_valid", instr_valid, 0);
    check("t6_req", imem_req, 0);
    check("t6_pc", pc, 0);
    check("t6_fields", {msb, opCode, operand}, 0);
    repeat (3) step();
    check("t6_idle", imem_req, 0);

    // sequential run across all opcodes
    for (int i = 0; i < 8; i++) mem[i] = {1'b0, 3'(i), 5'(i + 3)};
    do_start();
    for (int i = 0; i < 8; i++) begin
      fetch(1, a);
      check("t2_addr", a, i);
      check("t2_opc", opCode, i);
      check("t2_msb", msb, 0);
      exec(1, 1'b0, 8'h00, 1'b0);
    end
    check("t2_pc", pc, 8);

    // branches
    do_reset();
    do_start();
    fetch(0, a);
    exec(0, 1'b1, 8'd5, 1'b0);
    check("t3_pc5", pc, 5);
    fetch(1, a);
    check("t3_a5", a, 5);
    exec(1, 1'b1, 8'hFD, 1'b0);
    fetch(1, a);
    check("t3_a2", a, 2);
    exec(2, 1'b1, 8'h04, 1'b0);
    fetch(1, a);
    check("t3_a6", a, 6);
    exec(1, 1'b0, 8'h55, 1'b0);
    check("t3_pc7", pc, 7);

    // wrap at the top of the address space
    do_reset();
    do_start();
    fetch(1, a);
    exec(1, 1'b1, 8'hFF, 1'b0);
    check("t4_pc1023", pc, 1023);
    fetch(1, a);
    check("t4_a1023", a, 1023);
    exec(1, 1'b0, 8'h00, 1'b0);
    check("t4_pc0", pc, 0);
    fetch(1, a);
    check("t4_a0", a, 0);
    exec(1, 1'b0, 8'h00, 1'b0);
    fetch(1, a);
    check("t4_a1", a, 1);
    exec(1, 1'b1, 8'hFE, 1'b0);
    check("t4_neg", pc, 1023);
    fetch(1, a);
    check("t4_a1023b", a, 1023);

    // halt wins over a taken branch
    do_reset();
    do_start();
    fetch(1, a);
    exec(1, 1'b1, 8'd7, 1'b0);
    fetch(2, a);
    check("t5_a7", a, 7);
    exec(1, 1'b1, 8'h03, 1'b1);
    check("t5_done", done, 1);
    check("t5_pc", pc, 7);
    do_start();
    repeat (4) step();
    check("t5_done2", done, 1);
    check("t5_req", imem_req, 0);
    check("t5_pc2", pc, 7);
    check("t5_valid", instr_valid, 0);

    chk_en = 0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
